// File: rtl/fetch_unit_if.sv
// fetch_unit_if: instruction-memory port, decode control and IF/ID outputs of the fetch stage
interface fetch_unit_if;
  logic [31:0] o_imem_adr;
  logic [31:0] i_imem_dat;
  logic        i_stall;
  logic        i_redirect;
  logic [31:0] i_target;
  logic [31:0] o_pc;
  logic [31:0] o_pc4;
  logic [31:0] o_inst;
  logic        o_valid;
  modport master (
    output o_imem_adr, o_pc, o_pc4, o_inst, o_valid,
    input  i_imem_dat, i_stall, i_redirect, i_target
  );
  modport slave (
    input  o_imem_adr, o_pc, o_pc4, o_inst, o_valid,
    output i_imem_dat, i_stall, i_redirect, i_target
  );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: PC, instruction fetch and IF/ID register with stall, redirect and flush.
// Define FETCH_DELAY_SLOT_EN to keep the delay-slot word on redirect instead of flushing it.
module fetch_unit (
  input logic         i_clk,
  input logic         i_rst,
  fetch_unit_if.master bus
);
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP_INST = 32'h0000_0000;
`ifdef FETCH_DELAY_SLOT_EN
  localparam logic FLUSH_EN = 1'b0;
`else
  localparam logic FLUSH_EN = 1'b1;
`endif
  logic [31:0] pc_q, pc4, next_pc, pc_r, pc4_r, inst_r;
  logic        valid_r, flush;
  assign pc4     = pc_q + 32'd4;
  assign next_pc = bus.i_redirect ? {bus.i_target[31:2], 2'b00} : pc4;
  assign flush   = bus.i_redirect & FLUSH_EN;
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      pc_q    <= RESET_PC;
      pc_r    <= '0;
      pc4_r   <= '0;
      inst_r  <= NOP_INST;
      valid_r <= 1'b0;
    end else if (!bus.i_stall) begin
      pc_q    <= next_pc;
      pc_r    <= pc_q;
      pc4_r   <= pc4;
      inst_r  <= flush ? NOP_INST : bus.i_imem_dat;
      valid_r <= !flush;
    end
  end
  assign bus.o_imem_adr = pc_q;
  assign bus.o_pc       = pc_r;
  assign bus.o_pc4      = pc4_r;
  assign bus.o_inst     = inst_r;
  assign bus.o_valid    = valid_r;
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed plus random stimulus checked against an instruction-level fetch model
module tb_fetch_unit;
  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad = 0;
  fetch_unit_if bus ();
  fetch_unit dut (.i_clk(clk), .i_rst(rst), .bus(bus));
  always #5 clk = ~clk;
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC0DE_0001;
  endfunction
  assign bus.i_imem_dat = mem_word(bus.o_imem_adr);
  logic [31:0] m_pc, e_pc, e_pc4, e_inst;
  logic        e_valid;
`ifdef FETCH_DELAY_SLOT_EN
  localparam bit DS = 1'b1;
`else
  localparam bit DS = 1'b0;
`endif
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic step(input bit r, input bit s, input bit d, input logic [31:0] t);
    rst = r;
    bus.i_stall = s;
    bus.i_redirect = d;
    bus.i_target = t;
    if (r) begin
      m_pc = 32'h0;
      {e_pc, e_pc4, e_inst, e_valid} = '0;
    end else if (!s) begin
      e_pc = m_pc;
      e_pc4 = m_pc + 32'd4;
      e_valid = !d || DS;
      e_inst = e_valid ? mem_word(m_pc) : 32'h0;
      m_pc = d ? (t & ~32'd3) : m_pc + 32'd4;
    end
    @(posedge clk);
    #1;
    check("imem_adr", bus.o_imem_adr, m_pc);
    check("pc", bus.o_pc, e_pc);
    check("pc4", bus.o_pc4, e_pc4);
    check("inst", bus.o_inst, e_inst);
    check("valid", {31'd0, bus.o_valid}, {31'd0, e_valid});
  endtask
  initial begin
    m_pc = 0;
    {e_pc, e_pc4, e_inst, e_valid} = '0;
    step(1, 0, 0, 0);
    step(1, 0, 1, 32'h44);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 1, 0, 0);
    step(0, 1, 1, 32'h40);
    step(0, 1, 1, 32'h40);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 1, 32'h43);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 1, 32'h100);
    step(0, 0, 1, 32'h200);
    step(0, 0, 0, 0);
    step(0, 0, 1, 32'hFFFF_FFFE);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 1, 32'h20);
    step(0, 0, 0, 0);
    step(1, 0, 1, 32'h80);
    step(0, 0, 0, 0);
    step(0, 0, 1, 32'h30);
    step(1, 1, 1, 32'h90);
    step(0, 0, 0, 0);
    for (int i = 0; i < 300; i++)
      step($urandom_range(0, 99) < 3, $urandom_range(0, 99) < 20,
           $urandom_range(0, 99) < 20, $urandom);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage of the MIPS core, directly upstream of the instruction memory. Owns the program counter, drives the instruction-memory address, and captures the returned word into the IF/ID pipeline register with PC and PC+4 for decode. Supports stall from hazard logic, branch/jump redirect from decode, and wrong-path flush.

## Interface
- RESET_PC, 32'h0000_0000, PC loaded on reset
- NOP_INST, 32'h0000_0000, word placed in IF/ID on reset or flush (sll $0,$0,0)

- i_clk  in  1  clock, all state on rising edge
- i_rst  in  1  reset, synchronous, active-high
- o_imem_adr  out  32  instruction-memory address, equals current PC
- i_imem_dat  in  32  instruction word from memory, valid same cycle as o_imem_adr
- i_stall  in  1  hold PC and IF/ID
- i_redirect  in  1  taken branch/jump resolved in decode
- i_target  in  32  redirect target address
- o_pc  out  32  PC of instruction in IF/ID
- o_pc4  out  32  o_pc + 4
- o_inst  out  32  instruction in IF/ID
- o_valid  out  1  IF/ID holds a real instruction

## Operation
- State: pc_q (32b), IF/ID register {pc, pc4, inst, valid}.
- o_imem_adr = pc_q, combinational; memory read is combinational, so fetch completes in one cycle.
- next_pc = i_redirect ? {i_target[31:2],2'b00} : pc_q + 4. Low two target bits forced to 0. Addition modulo 2^32.
- Priority per edge: i_rst > i_stall > i_redirect > sequential.
- i_rst=1: pc_q<=RESET_PC; o_pc<=0, o_pc4<=0, o_inst<=NOP_INST, o_valid<=0.
- i_stall=1: pc_q and all IF/ID fields hold. i_redirect ignored; decode holds i_redirect/i_target until stall drops.
- Normal (no stall, no redirect): IF/ID <= {pc_q, pc_q+4, i_imem_dat, 1}; pc_q <= pc_q+4.
- Redirect (no stall): pc_q <= aligned target; IF/ID handling per Configuration (word fetched this cycle is the branch's successor).
- Flush sets o_inst=NOP_INST, o_valid=0; o_pc/o_pc4 still load pc_q/pc_q+4.

## Timing
- Reset output values: o_imem_adr=RESET_PC, o_pc=0, o_pc4=0, o_inst=NOP_INST, o_valid=0.
- First edge after i_rst falls: IF/ID captures instruction at RESET_PC (o_valid=1), o_imem_adr=RESET_PC+4.
- Fetch-to-IF/ID latency: 1 cycle. Redirect-to-target-in-IF/ID: 2 edges (edge 1 loads PC, edge 2 captures target word).
- Throughput: one instruction per cycle absent stall/redirect.
- Wrap: pc_q=32'hFFFF_FFFC advances to 32'h0000_0000, o_pc4 of that instruction = 0.
- Reset mid-stall or mid-redirect: reset wins; no partial state survives.
- Redirect on consecutive cycles: each accepted; latest target wins.

## Configuration
- FETCH_DELAY_SLOT_EN defined: MIPS branch delay slot. On redirect, the word fetched that cycle (branch PC+4) is captured normally with o_valid=1; no flush.
- Undefined: on redirect, IF/ID flushed (o_inst=NOP_INST, o_valid=0); delay-slot word discarded.
- Stall/reset behaviour identical in both builds.

## Test plan
- Reset: i_rst high 2 cycles, RESET_PC=0 -> o_imem_adr=0, o_valid=0, o_inst=0; one edge after release o_pc=0, o_pc4=4, o_inst=mem[0], o_valid=1, o_imem_adr=4.
- Sequential: 5 free cycles -> o_pc 0,4,8,12,16 with matching mem words, o_valid=1 throughout.
- Stall: i_stall=1 for 3 cycles with pc_q=8 -> o_imem_adr stays 8, IF/ID unchanged; also i_redirect=1 target 0x40 during stall -> ignored, pc_q stays 8.
- Redirect: branch at 0x10 in IF/ID, i_redirect=1 target 0x43 -> pc_q=0x40; without macro next o_valid=0, o_inst=NOP_INST, then o_pc=0x40; with FETCH_DELAY_SLOT_EN next o_pc=0x14, o_valid=1, then o_pc=0x40.
- Wrap: redirect to 0xFFFF_FFFC -> following fetch o_imem_adr=0, o_pc=0xFFFF_FFFC, o_pc4=0.
- Reset mid-run: i_rst asserted at pc_q=0x20 with pending redirect -> next edge all outputs at reset values, o_imem_adr=RESET_PC.
